// File: rtl/ant_table_arbiter.sv
// Arbitrates the N agent ports onto the single ant_routing_table lookup/update port.
// One transaction at a time: IDLE (arbitrate) -> ISSUE (drive table) -> RESP (ack + result).
module ant_table_arbiter #(
    parameter int N         = 5,
    parameter int M         = 5,
    parameter int DEST_W    = 6,
    parameter int UPD_BURST = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [0:N-1]                 i_req,
    input  logic [0:N-1]                 i_req_update,
    input  logic [0:N-1][DEST_W-1:0]     i_req_dest,
    output logic [0:N-1]                 o_ack,
    output logic [M-1:0]                 o_next_output,
    output logic                         o_busy,
    output logic                         o_tbl_update,
    output logic                         o_tbl_calculate_neighbor,
    output logic [DEST_W-1:0]            o_tbl_dest,
    output logic [0:N-1]                 o_tbl_parent,
    input  logic [M-1:0]                 i_tbl_next_output,
    output logic [1:0]                   o_dbg_state
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = $clog2(UPD_BURST + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   upd_cnt;
    logic [IDX_W-1:0]   lat_idx;
    logic               lat_upd;
    logic [DEST_W-1:0]  lat_dest;
    logic [M-1:0]       resp_q;

    // Handshake: a port raises i_req with stable i_req_update/i_req_dest and
    // holds them until it sees its o_ack pulse; inputs are only sampled at an
    // IDLE edge, so anything the port does while we are busy is ignored.
    logic [0:N-1]       upd_req, calc_req, cand;
    logic               any_req, upd_pend, calc_pend, force_calc, grant_upd;
    logic               found;
    logic [IDX_W-1:0]   grant_idx, pos;
    logic [IDX_W:0]     sum;

    assign upd_req    = i_req & i_req_update;
    assign calc_req   = i_req & ~i_req_update;
    assign any_req    = |i_req;
    assign upd_pend   = |upd_req;
    assign calc_pend  = |calc_req;
    assign force_calc = (upd_cnt == CNT_W'(UPD_BURST)) && calc_pend;
    assign grant_upd  = upd_pend && !force_calc;
    assign cand       = grant_upd ? upd_req : calc_req;

    // Round-robin search within the winning class, starting at rr_ptr.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        sum       = '0;
        pos       = '0;
        for (int off = 0; off < N; off++) begin
            sum = {1'b0, rr_ptr} + (IDX_W+1)'(off);
            pos = (sum >= (IDX_W+1)'(N)) ? IDX_W'(sum - (IDX_W+1)'(N)) : IDX_W'(sum);
            if (!found && cand[pos]) begin
                found     = 1'b1;
                grant_idx = pos;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            upd_cnt  <= '0;
            lat_idx  <= '0;
            lat_upd  <= 1'b0;
            lat_dest <= '0;
            resp_q   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE) begin
                if (any_req) begin
                    lat_idx  <= grant_idx;
                    lat_upd  <= grant_upd;
                    lat_dest <= i_req_dest[grant_idx];
                    rr_ptr   <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
                end
                // Burst counter only tracks updates that overtook a waiting calc.
                if (!calc_pend || !grant_upd)
                    upd_cnt <= '0;
                else if (upd_cnt != CNT_W'(UPD_BURST))
                    upd_cnt <= upd_cnt + 1'b1;
            end
            if (state == ST_ISSUE)
                resp_q <= lat_upd ? '0 : i_tbl_next_output;
        end
    end

    always_comb begin
        state_nxt                = state;
        o_ack                    = '0;
        o_next_output            = '0;
        o_busy                   = 1'b0;
        o_tbl_update             = 1'b0;
        o_tbl_calculate_neighbor = 1'b0;
        o_tbl_dest               = '0;
        o_tbl_parent             = '0;
        case (state)
            ST_IDLE: begin
                if (any_req) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_nxt                = ST_RESP;
                o_busy                   = 1'b1;
                o_tbl_update             = lat_upd;
                o_tbl_calculate_neighbor = ~lat_upd;
                o_tbl_dest               = lat_dest;
                o_tbl_parent             = N'(lat_idx);
            end
            ST_RESP: begin
                state_nxt        = ST_IDLE;
                o_busy           = 1'b1;
                o_ack[lat_idx]   = 1'b1;
                o_next_output    = resp_q;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign o_dbg_state = state;

endmodule

// File: tb/tb_ant_table_arbiter.sv
// Bench for ant_table_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level reference model of the arbitration rules.
module tb_ant_table_arbiter;

    localparam int N         = 5;
    localparam int M         = 5;
    localparam int DEST_W    = 6;
    localparam int UPD_BURST = 4;

    logic                     clk;
    logic                     reset;
    logic [0:N-1]             i_req;
    logic [0:N-1]             i_req_update;
    logic [0:N-1][DEST_W-1:0] i_req_dest;
    logic [0:N-1]             o_ack;
    logic [M-1:0]             o_next_output;
    logic                     o_busy;
    logic                     o_tbl_update;
    logic                     o_tbl_calculate_neighbor;
    logic [DEST_W-1:0]        o_tbl_dest;
    logic [0:N-1]             o_tbl_parent;
    logic [M-1:0]             i_tbl_next_output;
    logic [1:0]               o_dbg_state;

    ant_table_arbiter #(.N(N), .M(M), .DEST_W(DEST_W), .UPD_BURST(UPD_BURST)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .i_req                    (i_req),
        .i_req_update             (i_req_update),
        .i_req_dest               (i_req_dest),
        .o_ack                    (o_ack),
        .o_next_output            (o_next_output),
        .o_busy                   (o_busy),
        .o_tbl_update             (o_tbl_update),
        .o_tbl_calculate_neighbor (o_tbl_calculate_neighbor),
        .o_tbl_dest               (o_tbl_dest),
        .o_tbl_parent             (o_tbl_parent),
        .i_tbl_next_output        (i_tbl_next_output),
        .o_dbg_state              (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Table stand-in: one-hot output port derived from the destination.
    function automatic logic [M-1:0] tbl_fn(input logic [DEST_W-1:0] d);
        logic [M-1:0] r;
        r = '0;
        r[(int'(d) + 3) % M] = 1'b1;
        return r;
    endfunction
    assign i_tbl_next_output = tbl_fn(o_tbl_dest);

    function automatic logic [0:N-1] onehot(input int p);
        logic [0:N-1] v;
        v = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    // ---------------- checking ----------------
    int checks;
    int failures;
    int cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // ---------------- requesters ----------------
    bit                rq_v    [N];
    bit                rq_upd  [N];
    logic [DEST_W-1:0] rq_dest [N];
    bit                rq_hold [N];
    bit                rand_mode;
    int                rand_pct;

    task automatic set_req(input int p, input bit upd, input int dest, input bit hold);
        rq_v[p]    = 1'b1;
        rq_upd[p]  = upd;
        rq_dest[p] = DEST_W'(dest);
        rq_hold[p] = hold;
    endtask

    task automatic drive_inputs();
        for (int p = 0; p < N; p++) begin
            i_req[p]        = rq_v[p];
            i_req_update[p] = rq_upd[p];
            i_req_dest[p]   = rq_dest[p];
        end
    endtask

    task automatic requesters_react();
        for (int p = 0; p < N; p++) begin
            if (o_ack[p] && !rq_hold[p]) rq_v[p] = 1'b0;
            if (rand_mode && !rq_v[p] && $urandom_range(0, 99) < rand_pct)
                set_req(p, 1'($urandom_range(0, 1)), int'($urandom_range(0, 63)), 1'b0);
        end
    endtask

    // ---------------- reference model ----------------
    // m_phase counts the cycles of the current transaction (0 = none in flight).
    int                m_phase, m_idx, m_rr, m_cnt;
    bit                m_type;
    logic [DEST_W-1:0] m_dest;
    logic [M-1:0]      m_resp;
    logic [2:0]        exp_q[$];
    int                ack_log[$];
    int                ack_cyc[$];

    task automatic model_reset();
        m_phase = 0; m_idx = 0; m_rr = 0; m_cnt = 0;
        m_type = 1'b0; m_dest = '0; m_resp = '0;
        exp_q.delete();
    endtask

    task automatic model_edge();
        bit upd_pend, calc_pend, want_upd;
        int p;
        if (reset) begin
            model_reset();
            return;
        end
        case (m_phase)
            0: begin
                upd_pend = 1'b0; calc_pend = 1'b0;
                for (int q = 0; q < N; q++) begin
                    if (rq_v[q] && rq_upd[q])  upd_pend  = 1'b1;
                    if (rq_v[q] && !rq_upd[q]) calc_pend = 1'b1;
                end
                want_upd = upd_pend && !(m_cnt == UPD_BURST && calc_pend);
                if (upd_pend || calc_pend) begin
                    for (int off = N - 1; off >= 0; off--) begin
                        p = (m_rr + off) % N;
                        if (rq_v[p] && rq_upd[p] == want_upd) m_idx = p;
                    end
                    m_type  = want_upd;
                    m_dest  = rq_dest[m_idx];
                    m_rr    = (m_idx + 1) % N;
                    m_phase = 1;
                    exp_q.push_back(3'(m_idx));
                end
                if (!calc_pend || !want_upd) m_cnt = 0;
                else if (m_cnt < UPD_BURST)  m_cnt = m_cnt + 1;
            end
            1: begin
                m_resp  = m_type ? '0 : tbl_fn(m_dest);
                m_phase = 2;
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic compare_outputs();
        logic [0:N-1] e_ack;
        logic [2:0]   e;
        e_ack = (m_phase == 2) ? onehot(m_idx) : '0;
        check("busy",       32'(o_busy),                   32'(m_phase != 0));
        check("tbl_update", 32'(o_tbl_update),             32'(m_phase == 1 && m_type));
        check("tbl_calc",   32'(o_tbl_calculate_neighbor), 32'(m_phase == 1 && !m_type));
        check("ack",        32'(o_ack),                    32'(e_ack));
        check("next_out",   32'(o_next_output),            32'((m_phase == 2) ? m_resp : '0));
        if (m_phase == 1) begin
            check("tbl_dest",   32'(o_tbl_dest),   32'(m_dest));
            check("tbl_parent", 32'(o_tbl_parent), 32'(m_idx));
        end
        if (o_ack != '0) begin
            for (int p = 0; p < N; p++)
                if (o_ack[p]) begin
                    ack_log.push_back(p);
                    ack_cyc.push_back(cyc);
                end
            if (exp_q.size() == 0) begin
                check("ack_spurious", 32'(o_ack), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("ack_sb", 32'(o_ack), 32'(onehot(int'(e))));
            end
        end
    endtask

    // One clock: check at the falling edge, update stimulus, step the model,
    // then return just after the rising edge.
    task automatic cycle();
        @(negedge clk);
        compare_outputs();
        requesters_react();
        drive_inputs();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"},    32'(o_ack),                    32'd0);
        check({tag, "_next"},   32'(o_next_output),            32'd0);
        check({tag, "_busy"},   32'(o_busy),                   32'd0);
        check({tag, "_upd"},    32'(o_tbl_update),             32'd0);
        check({tag, "_calc"},   32'(o_tbl_calculate_neighbor), 32'd0);
        check({tag, "_dest"},   32'(o_tbl_dest),               32'd0);
        check({tag, "_parent"}, 32'(o_tbl_parent),             32'd0);
        check({tag, "_state"},  32'(o_dbg_state),              32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive_inputs();
        #1;
        check_all_zero("rst");
        model_reset();
        repeat (2) cycle();
        reset = 1'b0;
    endtask

    task automatic release_all();
        for (int p = 0; p < N; p++) rq_hold[p] = 1'b0;
    endtask

    task automatic drain(input string tag);
        bit quiet;
        quiet = 1'b0;
        release_all();
        rand_mode = 1'b0;
        for (int i = 0; i < 300 && !quiet; i++) begin
            cycle();
            quiet = (m_phase == 0) && (exp_q.size() == 0);
            for (int p = 0; p < N; p++) if (rq_v[p]) quiet = 1'b0;
        end
        check({tag, "_drain_done"}, 32'(quiet), 32'd1);
        repeat (2) cycle();
    endtask

    // ---------------- scenarios ----------------
    initial begin : main
        int exp_order2[7];
        int exp_order3[8];
        bit seen;
        int n1;
        exp_order2 = '{0, 1, 2, 3, 4, 0, 1};
        exp_order3 = '{0, 3, 0, 3, 1, 3, 0, 3};
        checks = 0; failures = 0; cyc = 0;
        rand_mode = 1'b0; rand_pct = 30;
        reset = 1'b0;
        for (int p = 0; p < N; p++) begin
            rq_v[p] = 1'b0; rq_upd[p] = 1'b0; rq_dest[p] = '0; rq_hold[p] = 1'b0;
        end
        drive_inputs();
        model_reset();
        #1;

        // All ports calc, held continuously from reset.
        for (int p = 0; p < N; p++) set_req(p, 1'b0, int'($urandom_range(0, 63)), 1'b1);
        do_reset();
        ack_log.delete(); ack_cyc.delete();
        for (int i = 0; i < 40 && ack_log.size() < 7; i++) cycle();
        check("t2_ack_count", 32'(ack_log.size() >= 7), 32'd1);
        for (int i = 0; i < 7 && i < ack_log.size(); i++)
            check($sformatf("t2_order%0d", i), 32'(ack_log[i]), 32'(exp_order2[i]));
        for (int i = 0; i < 6 && i + 1 < ack_cyc.size(); i++)
            check($sformatf("t2_spacing%0d", i), 32'(ack_cyc[i+1] - ack_cyc[i]), 32'd3);
        drain("t2");

        // Updates on ports 0 and 3 starve calc on port 1 for at most UPD_BURST grants.
        set_req(0, 1'b1, 11, 1'b1);
        set_req(3, 1'b1, 22, 1'b1);
        set_req(1, 1'b0, 33, 1'b1);
        do_reset();
        ack_log.delete(); ack_cyc.delete();
        for (int i = 0; i < 60 && ack_log.size() < 8; i++) cycle();
        check("t3_ack_count", 32'(ack_log.size() >= 8), 32'd1);
        for (int i = 0; i < 8 && i < ack_log.size(); i++)
            check($sformatf("t3_order%0d", i), 32'(ack_log[i]), 32'(exp_order3[i]));
        drain("t3");

        // Port 2 calc to dest 9; table answers one-hot port 2.
        set_req(2, 1'b0, 9, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle();
            if (o_tbl_calculate_neighbor) begin
                seen = 1'b1;
                check("t1_dest",   32'(o_tbl_dest),   32'd9);
                check("t1_parent", 32'(o_tbl_parent), 32'd2);
                check("t1_upd",    32'(o_tbl_update), 32'd0);
                cycle();
                check("t1_ack",    32'(o_ack),         32'b00100);
                check("t1_next",   32'(o_next_output), 32'b00100);
                check("t1_calc_off", 32'(o_tbl_calculate_neighbor), 32'd0);
            end
        end
        check("t1_seen", 32'(seen), 32'd1);
        drain("t1");

        // Port 4 update to dest 63: no result data on the ack.
        set_req(4, 1'b1, 63, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle();
            if (o_tbl_update) begin
                seen = 1'b1;
                check("t4_dest",   32'(o_tbl_dest),               32'd63);
                check("t4_parent", 32'(o_tbl_parent),             32'd4);
                check("t4_calc",   32'(o_tbl_calculate_neighbor), 32'd0);
                cycle();
                check("t4_upd_off", 32'(o_tbl_update),  32'd0);
                check("t4_ack",     32'(o_ack),         32'(onehot(4)));
                check("t4_next",    32'(o_next_output), 32'd0);
            end
        end
        check("t4_seen", 32'(seen), 32'd1);
        drain("t4");

        // Port 1 calc withdrawn during ISSUE still gets exactly one ack.
        set_req(1, 1'b0, 17, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle();
            if (o_tbl_calculate_neighbor) begin
                seen = 1'b1;
                rq_v[1] = 1'b0;
            end
        end
        check("t6_seen", 32'(seen), 32'd1);
        ack_log.delete(); ack_cyc.delete();
        repeat (10) cycle();
        n1 = 0;
        foreach (ack_log[i]) if (ack_log[i] == 1) n1++;
        check("t6_ack_once", 32'(n1), 32'd1);
        check("t6_idle", 32'(o_busy), 32'd0);
        drain("t6");

        // Reset in ISSUE: outputs clear at once, pointer restarts at port 0.
        set_req(3, 1'b0, 5, 1'b0);
        drain("t5a");
        set_req(2, 1'b0, 40, 1'b1);
        set_req(4, 1'b0, 50, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle();
            if (o_tbl_calculate_neighbor) begin
                seen = 1'b1;
                check("t5_parent_before", 32'(o_tbl_parent), 32'd4);
                reset = 1'b1;
                #1;
                check_all_zero("t5");
                model_reset();
                cycle();
                check_all_zero("t5_hold");
                reset = 1'b0;
            end
        end
        check("t5_seen", 32'(seen), 32'd1);
        ack_log.delete(); ack_cyc.delete();
        for (int i = 0; i < 10 && ack_log.size() < 1; i++) cycle();
        check("t5_first_ack", 32'(ack_log.size() >= 1 ? ack_log[0] : -1), 32'd2);
        drain("t5");

        // Random traffic against the model.
        rand_mode = 1'b1;
        repeat (2000) begin
            rand_pct = int'($urandom_range(5, 70));
            cycle();
        end
        drain("rand");
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
